// File: rtl/bus_cycle_ctrl_if.sv
// Core-side request/response and pin-side bus signals of the multiplexed
// address/data bus-cycle controller.
interface bus_cycle_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          req;
  logic [1:0]    req_type;
  logic          req_fetch;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          err;
  logic          busy;
  logic          ready;
  logic          hold;
  logic          hlda;
  logic          ctrl_oe;
  logic [AW-DW-1:0] haddr;
  logic [DW-1:0] ad_out;
  logic          ad_oe;
  logic [DW-1:0] ad_in;
  logic          ale;
  logic          rd_n;
  logic          wr_n;
  logic          io_m_n;
  logic          s0;
  logic          s1;

  modport slave (
    input  req, req_type, req_fetch, req_addr, req_wdata, ready, hold, ad_in,
    output ack, rdata, err, busy, hlda, ctrl_oe, haddr, ad_out, ad_oe,
           ale, rd_n, wr_n, io_m_n, s0, s1
  );

  modport master (
    output req, req_type, req_fetch, req_addr, req_wdata, ready, hold, ad_in,
    input  ack, rdata, err, busy, hlda, ctrl_oe, haddr, ad_out, ad_oe,
           ale, rd_n, wr_n, io_m_n, s0, s1
  );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// 8085-style machine-cycle sequencer: T1 (ALE/address/status), T2 strobe,
// ready-gated TW wait states with optional timeout, T3 data, plus hold/hlda.
module bus_cycle_ctrl #(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic            phi1,
  input  logic            rst,
  bus_cycle_ctrl_if.slave bus
);

  localparam int CW = (WAIT_TIMEOUT == 0) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = (WAIT_TIMEOUT == 0) ? '0 : CW'(WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_HOLD} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_type;
  logic          r_fetch;
  logic [DW-1:0] r_wdata;
  logic [CW-1:0] r_wcnt, w_wcnt_next;
  logic          r_flag, w_flag_next;
  logic          w_accept;

  logic             r_ack, r_err, r_busy, r_hlda, r_ctrl_oe, r_ale;
  logic             r_rd_n, r_wr_n, r_io_m_n, r_ad_oe;
  logic [1:0]       r_status;
  logic [DW-1:0]    r_ad_out, r_rdata;
  logic [AW-DW-1:0] r_haddr;

  // NOTE: every variable gets its default before the case so no path can leave it unassigned (no latch).
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_wcnt_next = r_wcnt;
    w_flag_next = r_flag;
    case (r_state)
      S_IDLE: begin
        // The ack cycle is a dead cycle: neither hold nor req is looked at.
        if (!r_ack) begin
          if (bus.hold) begin
            w_next = S_HOLD;
          end else if (bus.req) begin
            w_accept    = 1'b1;
            w_flag_next = 1'b0;
            w_next      = S_T1;
          end
        end
      end
      S_T1: w_next = S_T2;
      S_T2: begin
        if (bus.ready) begin
          w_next = S_T3;
        end else begin
          w_next      = S_TW;
          w_wcnt_next = '0;
        end
      end
      S_TW: begin
        if (bus.ready) begin
          w_next = S_T3;
        end else if (WAIT_TIMEOUT != 0 && r_wcnt == TO_LAST) begin
          w_flag_next = 1'b1;
          w_next      = S_T3;
        end else if (r_wcnt != '1) begin
          w_wcnt_next = r_wcnt + CW'(1);
        end
      end
      S_T3:    w_next = S_IDLE;
      S_HOLD:  if (!bus.hold) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the request fields must
  // come straight from the core on the accepting edge.
  logic [1:0] w_type;
  logic       w_fetch, w_write, w_busy, w_strobe;
  logic [1:0] w_status;

  assign w_type   = w_accept ? bus.req_type  : r_type;
  assign w_fetch  = w_accept ? bus.req_fetch : r_fetch;
  assign w_write  = w_type[0];
  assign w_busy   = w_next inside {S_T1, S_T2, S_TW, S_T3};
  assign w_strobe = w_next inside {S_T2, S_TW, S_T3};
  assign w_status = w_write ? 2'b01 : (w_fetch && !w_type[1]) ? 2'b11 : 2'b10;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge phi1 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_type  <= '0;
      r_fetch <= 1'b0;
      r_wdata <= '0;
      r_wcnt  <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= w_wcnt_next;
      r_flag  <= w_flag_next;
      if (w_accept) begin
        r_type  <= bus.req_type;
        r_fetch <= bus.req_fetch;
        r_wdata <= bus.req_wdata;
      end
    end
  end

  always_ff @(posedge phi1 or posedge rst) begin
    if (rst) begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_hlda    <= 1'b0;
      r_ctrl_oe <= 1'b1;
      r_ale     <= 1'b0;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_io_m_n  <= 1'b0;
      r_status  <= 2'b00;
      r_ad_oe   <= 1'b0;
      r_ad_out  <= '0;
      r_haddr   <= '0;
      r_rdata   <= '0;
    end else begin
      r_ack     <= (r_state == S_T3);
      r_err     <= (r_state == S_T3) && r_flag;
      r_busy    <= w_busy;
      r_hlda    <= (w_next == S_HOLD);
      r_ctrl_oe <= (w_next != S_HOLD);
      r_ale     <= (w_next == S_T1);
      r_rd_n    <= !(w_strobe && !w_write);
      r_wr_n    <= !(w_strobe && w_write);
      r_io_m_n  <= w_busy && w_type[1];
      r_status  <= w_busy ? w_status : 2'b00;
      r_ad_oe   <= (w_next == S_T1) || (w_strobe && w_write);
      if (w_next == S_T1) begin
        r_ad_out <= bus.req_addr[DW-1:0];
        r_haddr  <= bus.req_addr[AW-1:DW];
      end else if (w_strobe && w_write) begin
        r_ad_out <= r_wdata;
      end
      if (r_state == S_T3 && !r_type[0]) r_rdata <= bus.ad_in;
    end
  end

  assign bus.ack     = r_ack;
  assign bus.err     = r_err;
  assign bus.busy    = r_busy;
  assign bus.hlda    = r_hlda;
  assign bus.ctrl_oe = r_ctrl_oe;
  assign bus.ale     = r_ale;
  assign bus.rd_n    = r_rd_n;
  assign bus.wr_n    = r_wr_n;
  assign bus.io_m_n  = r_io_m_n;
  assign bus.s1      = r_status[1];
  assign bus.s0      = r_status[0];
  assign bus.ad_oe   = r_ad_oe;
  assign bus.ad_out  = r_ad_out;
  assign bus.haddr   = r_haddr;
  assign bus.rdata   = r_rdata;

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- Parametrised multiplexed address/data bus-cycle controller, 8085-style, sitting between the core's decoding/control path and the external pins.
- Runs one machine cycle per core request: T1 (ALE, address, status), T2 (strobe), optional TW wait states gated by ready, and T3 (data).
- Adds configurable address and data widths, ready-driven wait states with a timeout, and a hold/hlda bus handoff.

Parameters:
AW, 16, total address width (AW > DW)
DW, 8, data width; the low DW address bits are multiplexed on the AD pins
WAIT_TIMEOUT, 0, maximum TW cycles before a forced abort; 0 disables the timeout

Ports:
phi1  in  1  clock; all state advances on the rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  core request, level; must be dropped in the cycle ack is high
req_type  in  2  00 mem read, 01 mem write, 10 io read, 11 io write
req_fetch  in  1  opcode fetch qualifier; meaningful for mem read only
req_addr  in  AW  transaction address
req_wdata  in  DW  write data
ack  out  1  one-cycle completion pulse
rdata  out  DW  read data; valid while ack is high, held until the next read
err  out  1  timeout abort, valid with ack
busy  out  1  high in T1, T2, TW, T3
ready  in  1  external ready, sampled at end of T2/TW
hold  in  1  external bus hold request
hlda  out  1  hold acknowledge
ctrl_oe  out  1  pad enable for ale/rd_n/wr_n/io_m_n/s0/s1/haddr; 0 in HOLD
haddr  out  AW-DW  high address bits
ad_out  out  DW  AD pin output value
ad_oe  out  1  AD pin output enable
ad_in  in  DW  AD pin input value
ale  out  1  address latch enable
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low
io_m_n  out  1  1 = io, 0 = memory
s0  out  1  status bit 0
s1  out  1  status bit 1

Behaviour:
- All outputs are registered. Reset values: ack=0, err=0, busy=0, hlda=0, ctrl_oe=1, ale=0, rd_n=1, wr_n=1, ad_oe=0, ad_out=0, haddr=0, rdata=0, io_m_n=0, s1=0, s0=0, state IDLE, wait counter 0.
- Reset is asynchronous: asserting rst in any state immediately forces the reset values. The in-flight transaction is dropped and produces no ack.
- States: IDLE, T1, T2, TW, T3, HOLD.
- IDLE, decisions in priority order:
  - In the ack cycle, req is ignored.
  - Otherwise hold=1 goes to HOLD; hold wins over a simultaneous req.
  - Otherwise req=1 latches addr, type, fetch and wdata, then goes to T1.
- T1: ale=1, ad_oe=1, ad_out=addr[DW-1:0], haddr=addr[AW-1:DW]. io_m_n=type[1]. Status {s1,s0}: 11 for fetch, 10 for read, 01 for write. Status and io_m_n hold through T3 and return to 00/0 in IDLE. Always goes to T2.
- T2:
  - Read: ale=0, ad_oe=0, rd_n=0.
  - Write: ale=0, ad_out=wdata, ad_oe=1, wr_n=0.
  - ready=1 goes to T3; ready=0 goes to TW and clears the wait counter.
- TW: strobes and AD drive held; the wait counter increments each cycle.
  - ready=1 goes to T3.
  - If WAIT_TIMEOUT≠0 and the counter reaches WAIT_TIMEOUT-1 with ready=0, an error flag is set and the state goes to T3.
  - ready=1 on the timeout cycle gives a normal completion with no error.
- T3: strobes held. On the edge leaving T3:
  - rd_n=1, wr_n=1, ad_oe=0.
  - A read captures ad_in into rdata, including on timeout.
  - ack=1 and err=flag for one cycle; the next state is IDLE.
- Latency: zero-wait cycle is T1-T2-T3 with ack in the 4th cycle. Each ready-low cycle adds one TW. The earliest next T1 is 2 cycles after ack (ack cycle, then IDLE accepts).
- HOLD: the cycle after entry, hlda=1, ctrl_oe=0, ad_oe=0, strobes inactive. When hold=0, go to IDLE; hlda=0 and ctrl_oe=1 the next cycle.
- hold asserted during T1..T3 is deferred until after the ack cycle.
- Wait counter width is clog2(WAIT_TIMEOUT+1), minimum 1. It saturates when WAIT_TIMEOUT=0.
- Changes to req_addr, req_type or req_wdata after acceptance have no effect on the current cycle.

Test Plan:
1. Reset: assert rst mid-TW of a write -> same cycle wr_n=1, ad_oe=0, busy=0, no ack after release; a subsequent mem read completes normally.
2. Mem read, AW=16 DW=8, addr 0x1234, ready=1, ad_in=0xA5 in T3 -> T1: ale=1, ad_out=0x34, haddr=0x12, {s1,s0}=10, io_m_n=0; T2: rd_n=0; cycle 4: ack=1, rdata=0xA5, err=0.
3. IO write addr 0x0042 data 0x5C, ready low for 2 cycles -> T1, T2, TW, TW, T3; wr_n=0 for 4 cycles; ad_out=0x5C with ad_oe=1 from T2 to T3; io_m_n=1; ack in cycle 6.
4. WAIT_TIMEOUT=4, ready stuck 0 on a mem read -> exactly 4 TW cycles, then T3; ack=1 with err=1; next zero-wait read has err=0.
5. hold raised during T2 of a read -> read completes with ack; hlda=1 two cycles after ack, ctrl_oe=0; a req held during HOLD starts T1 only after hold drops and hlda clears.
6. AW=20 DW=16, fetch at 0xABCDE -> T1: ad_out=0xBCDE, haddr=0xA, {s1,s0}=11; hold and req raised together in IDLE -> HOLD is entered first.
